// File: rtl/prewish_mask_player.sv
// Blink-mask player: captures masks on strobe rising edges, double-buffers them,
// and shifts the active mask MSB-first onto the LED once per prescaler tick.
module prewish_mask_player #(
    parameter int MASK_CLK_BITS = 10,
    parameter int DATA_W        = 8
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              STB_I,
    input  logic [DATA_W-1:0] DAT_I,
    output logic              ACK_O,
    output logic              OVR_O,
    output logic              BUSY_O,
    output logic              o_led
);

    localparam int IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(DATA_W - 2);

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    state_t                   state;
    logic [1:0]               rst_sync;
    logic                     rst_n;
    logic                     stb_q;
    logic                     pend_v;
    logic [DATA_W-1:0]        cur;
    logic [DATA_W-1:0]        pend;
    logic [DATA_W-1:0]        nxt;
    logic [IDX_W-1:0]         bit_idx;
    logic [MASK_CLK_BITS-1:0] presc;
    logic                     rise;
    logic                     tick;
    logic                     boundary;
    logic                     consume;

    // Reset asserts asynchronously but releases two clock edges later.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    always_comb begin
        rise     = STB_I & ~stb_q;
        tick     = &presc;
        boundary = (state == PLAY) && tick && (bit_idx == LAST_IDX);
        consume  = pend_v && ((state == IDLE) || boundary);
        nxt      = pend_v ? pend : cur;
    end

    // Pending buffer: a capture on the consume edge lands behind the consumed mask.
    always_ff @(posedge CLK_I or negedge rst_n) begin
        if (!rst_n) begin
            stb_q  <= 1'b0;
            pend   <= '0;
            pend_v <= 1'b0;
            ACK_O  <= 1'b0;
            OVR_O  <= 1'b0;
        end else begin
            stb_q <= STB_I;
            ACK_O <= rise;
            OVR_O <= rise & pend_v & ~consume;
            if (rise) begin
                pend   <= DAT_I;
                pend_v <= 1'b1;
            end else if (consume) begin
                pend_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_I or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur     <= '0;
            bit_idx <= '0;
            presc   <= '0;
            o_led   <= 1'b0;
            BUSY_O  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    presc   <= '0;
                    bit_idx <= '0;
                    if (pend_v && (pend != '0)) begin
                        cur    <= pend;
                        o_led  <= pend[DATA_W-1];
                        BUSY_O <= 1'b1;
                        state  <= PLAY;
                    end else begin
                        o_led <= 1'b0;
                    end
                end
                PLAY: begin
                    presc <= presc + 1'b1;
                    if (tick) begin
                        if (bit_idx != LAST_IDX) begin
                            bit_idx <= bit_idx + 1'b1;
                            o_led   <= cur[PRE_LAST - bit_idx];
                        end else begin
                            bit_idx <= '0;
                            if (nxt == '0) begin
                                o_led  <= 1'b0;
                                BUSY_O <= 1'b0;
                                state  <= IDLE;
                            end else begin
                                cur   <= nxt;
                                o_led <= nxt[DATA_W-1];
                            end
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_led  <= 1'b0;
                    BUSY_O <= 1'b0;
                end
            endcase
        end
    end

endmodule
